// File: rtl/sample_bram_read_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | sample_bram_read_arbiter_pkg : shared constants, requester ids and read tags |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
package sample_bram_read_arbiter_pkg;

    localparam int NUM_OSCILLATORS = 4;
    localparam int WW_WIDTH        = 18;
    localparam int SAMPLE_WIDTH    = 16;
    localparam int BRAM_LATENCY    = 2;

    typedef enum logic [2:0] {
        OSC0 = 3'd0,
        OSC1 = 3'd1,
        OSC2 = 3'd2,
        OSC3 = 3'd3,
        DBG  = 3'd4
    } req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

    function automatic logic tag_hit(rd_tag_t tag, req_id_t id);
        return tag.vld && (tag.id == id);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_bram_read_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | sample_bram_read_arbiter_if : requester, debug and BRAM read-port bundle     |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
interface sample_bram_read_arbiter_if
    import sample_bram_read_arbiter_pkg::*;
#(
    parameter int NUM_OSC = NUM_OSCILLATORS,
    parameter int ADDR_W  = WW_WIDTH,
    parameter int DATA_W  = SAMPLE_WIDTH
);
    logic [NUM_OSC-1:0]        osc_req_in;
    logic [NUM_OSC*ADDR_W-1:0] osc_addr_in;
    logic [NUM_OSC-1:0]        osc_grant_out;
    logic [NUM_OSC-1:0]        osc_valid_out;
    logic [NUM_OSC*DATA_W-1:0] osc_data_out;
    logic                      dbg_req_in;
    logic [ADDR_W-1:0]         dbg_addr_in;
    logic                      dbg_grant_out;
    logic                      dbg_valid_out;
    logic [DATA_W-1:0]         dbg_data_out;
    logic [ADDR_W-1:0]         bram_addr_out;
    logic [DATA_W-1:0]         bram_data_in;

    modport slave (
        input  osc_req_in, osc_addr_in, dbg_req_in, dbg_addr_in, bram_data_in,
        output osc_grant_out, osc_valid_out, osc_data_out,
        output dbg_grant_out, dbg_valid_out, dbg_data_out, bram_addr_out
    );

    modport master (
        output osc_req_in, osc_addr_in, dbg_req_in, dbg_addr_in, bram_data_in,
        input  osc_grant_out, osc_valid_out, osc_data_out,
        input  dbg_grant_out, dbg_valid_out, dbg_data_out, bram_addr_out
    );

endinterface
`default_nettype wire

// File: rtl/sample_bram_read_arbiter_read_tag_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | sample_bram_read_arbiter_read_tag_pipe : read-tag delay line, sync clear     |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module sample_bram_read_arbiter_read_tag_pipe
    import sample_bram_read_arbiter_pkg::*;
#(
    parameter int DEPTH = BRAM_LATENCY
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  rd_tag_t   tag_in,
    output rd_tag_t   tag_out
);
    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sample_bram_read_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | sample_bram_read_arbiter : slot scheduler sharing the sample-BRAM read port  |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module sample_bram_read_arbiter
    import sample_bram_read_arbiter_pkg::*;
#(
    parameter int NUM_OSC  = NUM_OSCILLATORS,
    parameter int ADDR_W   = WW_WIDTH,
    parameter int DATA_W   = SAMPLE_WIDTH,
    parameter int BRAM_LAT = BRAM_LATENCY
) (
    input  wire logic                 clk_in,
    input  wire logic                 rst_in,
    sample_bram_read_arbiter_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_OSC + 1);
    localparam int ID_W   = $bits(req_id_t);

    logic [SLOT_W-1:0]         slot_q, slot_d;
    rd_tag_t                   grant_q, grant_d;
    rd_tag_t                   ret_tag, ret_q;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [NUM_OSC*DATA_W-1:0] osc_data_q;
    logic [DATA_W-1:0]         dbg_data_q;
    logic [NUM_OSC-1:0]        osc_grant, osc_valid, osc_elig;
    logic                      dbg_elig;
    logic                      own_hit, low_hit;
    req_id_t                   own_id, low_id;

    function automatic req_id_t osc_id(int k);
        return req_id_t'(ID_W'(k));
    endfunction

    always_comb begin
        osc_grant = '0;
        osc_valid = '0;
        for (int k = 0; k < NUM_OSC; k++) begin
            osc_grant[k] = tag_hit(grant_q, osc_id(k));
            osc_valid[k] = tag_hit(ret_q, osc_id(k));
        end
    end

    // Whoever holds the grant this cycle sits out the next decision.
    assign osc_elig = bus.osc_req_in & ~osc_grant;
    assign dbg_elig = bus.dbg_req_in & ~tag_hit(grant_q, DBG);

    always_comb begin
        own_hit = 1'b0;
        own_id  = OSC0;
        low_hit = 1'b0;
        low_id  = OSC0;
        for (int k = 0; k < NUM_OSC; k++) begin
            if (slot_q == SLOT_W'(k) && osc_elig[k]) begin
                own_hit = 1'b1;
                own_id  = osc_id(k);
            end
        end
        for (int k = NUM_OSC - 1; k >= 0; k--) begin
            if (osc_elig[k]) begin
                low_hit = 1'b1;
                low_id  = osc_id(k);
            end
        end
    end

    always_comb begin
        grant_d = '0;
        if (slot_q == SLOT_W'(NUM_OSC)) begin
            if (dbg_elig) begin
                grant_d.vld = 1'b1;
                grant_d.id  = DBG;
            end else if (low_hit) begin
                grant_d.vld = 1'b1;
                grant_d.id  = low_id;
            end
        end else if (own_hit) begin
            grant_d.vld = 1'b1;
            grant_d.id  = own_id;
        end else if (dbg_elig) begin
            grant_d.vld = 1'b1;
            grant_d.id  = DBG;
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (grant_d.vld) begin
            if (grant_d.id == DBG) begin
                addr_d = bus.dbg_addr_in;
            end
            for (int k = 0; k < NUM_OSC; k++) begin
                if (grant_d.id == osc_id(k)) begin
                    addr_d = bus.osc_addr_in[k*ADDR_W +: ADDR_W];
                end
            end
        end
        slot_d = (slot_q == SLOT_W'(NUM_OSC)) ? '0 : slot_q + SLOT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q     <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            ret_q      <= '0;
            osc_data_q <= '0;
            dbg_data_q <= '0;
        end else begin
            slot_q  <= slot_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            ret_q   <= ret_tag;
            if (ret_tag.vld) begin
                if (ret_tag.id == DBG) begin
                    dbg_data_q <= bus.bram_data_in;
                end
                for (int k = 0; k < NUM_OSC; k++) begin
                    if (ret_tag.id == osc_id(k)) begin
                        osc_data_q[k*DATA_W +: DATA_W] <= bus.bram_data_in;
                    end
                end
            end
        end
    end

    // The grant register itself enters the pipe, so the tag emerges as the BRAM data does.
    sample_bram_read_arbiter_read_tag_pipe #(
        .DEPTH (BRAM_LAT)
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tag_in  (grant_q),
        .tag_out (ret_tag)
    );

    assign bus.osc_grant_out = osc_grant;
    assign bus.osc_valid_out = osc_valid;
    assign bus.osc_data_out  = osc_data_q;
    assign bus.dbg_grant_out = tag_hit(grant_q, DBG);
    assign bus.dbg_valid_out = tag_hit(ret_q, DBG);
    assign bus.dbg_data_out  = dbg_data_q;
    assign bus.bram_addr_out = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_bram_read_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_sample_bram_read_arbiter : randomized scoreboard bench for the arbiter    |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sample_bram_read_arbiter;
    localparam int NO   = 4;
    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int NREQ = NO + 1;

    localparam int M_IDLE    = 0;
    localparam int M_RAND    = 1;
    localparam int M_FULL    = 2;
    localparam int M_T4      = 3;
    localparam int M_DSTREAM = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mode = M_IDLE;
    int   shot_id = 0;
    logic [AW-1:0] shot_addr = '0;
    logic shot_armed = 1'b0;
    int   ds_sent = 0;
    logic [AW-1:0] ds_addr = '0;
    int   dbg_vcount = 0;

    exp_t sb [NREQ][$];
    int   m_slot = 0;
    int   m_mask = -1;
    int   m_win = -1;
    logic [AW-1:0] m_bram_addr = '0;
    logic [NREQ-1:0] m_req;
    logic [AW-1:0] m_addr [NREQ];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_bram_read_arbiter_if #(.NUM_OSC(NO), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sample_bram_read_arbiter #(
        .NUM_OSC(NO), .ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(LAT)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // BRAM: data = addr[15:0] ^ A5A5, valid LAT cycles after the address is registered
    logic [DW-1:0] bram_pipe [LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= bus.bram_addr_out[15:0] ^ 16'hA5A5;
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bus.bram_data_in = bram_pipe[LAT-1];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic granted(int k);
        return (k < NO) ? bus.osc_grant_out[k] : bus.dbg_grant_out;
    endfunction
    function automatic logic valid_of(int k);
        return (k < NO) ? bus.osc_valid_out[k] : bus.dbg_valid_out;
    endfunction
    function automatic logic req_of(int k);
        return (k < NO) ? bus.osc_req_in[k] : bus.dbg_req_in;
    endfunction
    function automatic logic [AW-1:0] addr_of(int k);
        return (k < NO) ? bus.osc_addr_in[k*AW +: AW] : bus.dbg_addr_in;
    endfunction
    function automatic logic [DW-1:0] data_of(int k);
        return (k < NO) ? bus.osc_data_out[k*DW +: DW] : bus.dbg_data_out;
    endfunction
    function automatic logic [AW-1:0] rnd();
        return AW'($urandom);
    endfunction

    task automatic set_req(int k, logic r, logic [AW-1:0] a);
        if (k < NO) begin
            bus.osc_req_in[k] = r;
            bus.osc_addr_in[k*AW +: AW] = a;
        end else begin
            bus.dbg_req_in = r;
            bus.dbg_addr_in = a;
        end
    endtask

    // Reference: round of NO+1 slots counted from reset; owner first, debug fallback,
    // last slot debug-first then lowest oscillator; the previous winner sits out.
    function automatic int choose(int slot, logic [NREQ-1:0] req, int mask);
        logic [NREQ-1:0] el;
        el = req;
        if (mask >= 0) el[mask] = 1'b0;
        if (slot < NO) begin
            if (el[slot]) return slot;
            if (el[NO]) return NO;
            return -1;
        end
        if (el[NO]) return NO;
        for (int k = 0; k < NO; k++) if (el[k]) return k;
        return -1;
    endfunction

    // Requester behaviour: react to grant pulses, hold requests until granted
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NREQ; k++) begin
            logic g;
            g = granted(k);
            case (mode)
                M_RAND: begin
                    if (g) begin
                        if ($urandom_range(1) == 1) set_req(k, 1'b1, rnd());
                        else set_req(k, 1'b0, addr_of(k));
                    end else if (!req_of(k) && $urandom_range(9) < 3) begin
                        set_req(k, 1'b1, rnd());
                    end
                end
                M_FULL: if (g || !req_of(k)) set_req(k, 1'b1, rnd());
                M_T4: begin
                    if (k == 0 || k == 2 || k == NO) begin
                        if (g || !req_of(k)) set_req(k, 1'b1, rnd());
                    end else set_req(k, 1'b0, addr_of(k));
                end
                M_DSTREAM: begin
                    if (k == NO) begin
                        if (g) begin
                            ds_sent++;
                            ds_addr = ds_addr + 1'b1;
                        end
                        set_req(k, ds_sent < 10, ds_addr);
                    end else set_req(k, 1'b0, addr_of(k));
                end
                default: begin
                    if (shot_armed && k == shot_id) begin
                        if (g) begin
                            set_req(k, 1'b0, shot_addr);
                            shot_armed = 1'b0;
                        end else set_req(k, 1'b1, shot_addr);
                    end else set_req(k, 1'b0, addr_of(k));
                end
            endcase
        end
    end

    // Model: decide at each edge, check grants/address just after it, queue expected returns
    always @(posedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            m_req[k]  = req_of(k);
            m_addr[k] = addr_of(k);
        end
        if (rst) begin
            m_slot = 0;
            m_mask = -1;
            m_win = -1;
            m_bram_addr = '0;
            for (int k = 0; k < NREQ; k++) sb[k].delete();
        end else begin
            m_win = choose(m_slot, m_req, m_mask);
            m_mask = m_win;
            m_slot = (m_slot + 1) % NREQ;
            if (m_win >= 0) m_bram_addr = m_addr[m_win];
        end
        #1;
        for (int k = 0; k < NREQ; k++)
            chk($sformatf("grant%0d", k), 32'(granted(k)), 32'(k == m_win));
        chk("bram_addr", 32'(bus.bram_addr_out), 32'(m_bram_addr));
        if (m_win >= 0) begin
            exp_t e;
            e.data = m_addr[m_win][15:0] ^ 16'hA5A5;
            e.due  = cyc + LAT + 1;
            sb[m_win].push_back(e);
        end
    end

    // Monitor: every valid pulse pops its requester's queue
    always @(negedge clk) begin
        int nv;
        nv = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (valid_of(k) === 1'b1) begin
                nv++;
                if (k == NO) dbg_vcount++;
                if (sb[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid%0d: got valid expected none (t=%0t)", k, $time);
                end else begin
                    exp_t e;
                    e = sb[k].pop_front();
                    chk($sformatf("data%0d", k), 32'(data_of(k)), 32'(e.data));
                    chk($sformatf("latency%0d", k), cyc, e.due);
                end
            end
        end
        if (nv > 0) chk("single_valid", nv, 1);
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_state_checks(string tag);
        chk({tag, "_grants"}, 32'({bus.osc_grant_out, bus.dbg_grant_out}), 32'd0);
        chk({tag, "_valids"}, 32'({bus.osc_valid_out, bus.dbg_valid_out}), 32'd0);
        chk({tag, "_bram_addr"}, 32'(bus.bram_addr_out), 32'd0);
        chk({tag, "_osc_data_lo"}, bus.osc_data_out[31:0], 32'd0);
        chk({tag, "_osc_data_hi"}, bus.osc_data_out[63:32], 32'd0);
        chk({tag, "_dbg_data"}, 32'(bus.dbg_data_out), 32'd0);
    endtask

    task automatic shot(int id, logic [AW-1:0] a, string name);
        int t;
        @(negedge clk);
        shot_id = id;
        shot_addr = a;
        shot_armed = 1'b1;
        t = 0;
        while (shot_armed && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_granted"}, 32'(shot_armed), 32'd0);
    endtask

    initial begin
        int c0;
        bus.osc_req_in = '0;
        bus.osc_addr_in = '0;
        bus.dbg_req_in = 1'b0;
        bus.dbg_addr_in = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        reset_state_checks("reset");

        // single oscillator read, then debug read at the top of the address range
        shot(2, 18'h00100, "t1");
        idle(6);
        chk("t1_data", 32'(bus.osc_data_out[2*DW +: DW]), 32'h0000A4A5);
        shot(NO, 18'h3FFFF, "t6");
        idle(6);
        chk("t6_bram_addr", 32'(bus.bram_addr_out), 32'h0003FFFF);
        chk("t6_data", 32'(bus.dbg_data_out), 32'h00005A5A);

        // full audio + debug load
        mode = M_FULL;
        idle(50);
        mode = M_IDLE;
        idle(8);

        // debug shares idle oscillator slots
        mode = M_T4;
        idle(60);
        mode = M_IDLE;
        idle(8);

        // debug streaming alone
        ds_sent = 0;
        ds_addr = '0;
        c0 = dbg_vcount;
        mode = M_DSTREAM;
        begin
            int t;
            t = 0;
            while (dbg_vcount - c0 < 10 && t < 25) begin
                @(negedge clk);
                t++;
            end
        end
        chk("t3_dbg_count", dbg_vcount - c0, 10);
        mode = M_IDLE;
        idle(8);

        // reset one cycle after a grant drops the read
        shot(0, 18'h01234, "t5");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_state_checks("t5");
        idle(8);

        // randomized traffic
        mode = M_RAND;
        idle(2000);
        mode = M_IDLE;
        idle(12);
        for (int k = 0; k < NREQ; k++)
            chk($sformatf("drained%0d", k), sb[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
